// File: rtl/cpu_debug_ocimem.sv
// OCI debug RAM and JTAG monitor data path for the debug core.
// Arbitrates JTAG (jdo/take_*) and Avalon-MM slave access to one RAM.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   jdo, take_*             JTAG data and one-cycle command pulses
//   address..debugaccess    Avalon-MM slave request
//   readdata, waitrequest   Avalon-MM slave response
//   MonDReg, jtag_busy      monitor data back to the wrapper, JTAG busy
//
// Option: define OCIMEM_DEBUGACCESS_PROTECT_EN to drop Avalon writes
// that arrive with debugaccess=0 (handshake still completes).

module cpu_debug_ocimem #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    J_RD,
    J_WR,
    AV_RD,
    AV_ACK
  } state_t;

  state_t state_q, state_d;

  logic              jrd_q, jrd_d;
  logic              jwr_q, jwr_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;
  logic              ram_re;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;

  logic              take_rd;
  logic              take_any;
  logic              av_we_ok;
  logic              wait_c;
  logic              unused_ok;

  assign take_rd  = (take_action_ocimem_a & jdo[17])
                  | take_no_action_ocimem_a;
  assign take_any = take_action_ocimem_a
                  | take_action_ocimem_b
                  | take_no_action_ocimem_a;

`ifdef OCIMEM_DEBUGACCESS_PROTECT_EN
  assign av_we_ok = debugaccess;
`else
  assign av_we_ok = 1'b1;
`endif

  assign unused_ok = ^{jdo, debugaccess, (INIT_FILE == "")};

  // Single-port RAM, registered read, contents not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) begin
          mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
    if (ram_re) begin
      ram_q <= mem[ram_addr];
    end
  end

  always_comb begin
    state_d   = state_q;
    jrd_d     = jrd_q;
    jwr_d     = jwr_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    rdata_d   = rdata_q;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = mon_a_q;
    ram_wdata = mon_d_q;
    ram_be    = 4'hF;
    wait_c    = 1'b1;

    unique case (state_q)
      IDLE: begin
        // A take_* pulse this cycle stalls the arbiter so the
        // JTAG op it raises is serviced ahead of Avalon.
        if (!ready_q || take_any) begin
          state_d = IDLE;
        end else if (jwr_q) begin
          state_d = J_WR;
        end else if (jrd_q) begin
          state_d = J_RD;
          ram_re  = 1'b1;
        end else if (write) begin
          ram_we    = av_we_ok;
          ram_addr  = address;
          ram_wdata = writedata;
          ram_be    = byteenable;
          wait_c    = 1'b0;
          state_d   = AV_ACK;
        end else if (read) begin
          ram_re   = 1'b1;
          ram_addr = address;
          state_d  = AV_RD;
        end else begin
          wait_c = 1'b0;
        end
      end
      J_WR: begin
        ram_we  = 1'b1;
        jwr_d   = 1'b0;
        mon_a_d = mon_a_q + 1'b1;
        state_d = IDLE;
      end
      J_RD: begin
        mon_d_d = ram_q;
        jrd_d   = 1'b0;
        mon_a_d = mon_a_q + 1'b1;
        state_d = IDLE;
      end
      AV_RD: begin
        rdata_d = ram_q;
        wait_c  = 1'b0;
        state_d = IDLE;
      end
      AV_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New JTAG commands win over the in-flight op's updates.
    if (take_action_ocimem_a) begin
      mon_a_d = jdo[26 +: ADDR_W];
    end
    if (take_action_ocimem_b) begin
      mon_d_d = jdo[34:3];
      jwr_d   = 1'b1;
    end
    if (take_rd) begin
      jrd_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      jrd_q   <= 1'b0;
      jwr_q   <= 1'b0;
      mon_a_q <= '0;
      mon_d_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      jrd_q   <= jrd_d;
      jwr_q   <= jwr_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      rdata_q <= rdata_d;
      ready_q <= 1'b1;
    end
  end

  // Read data is presented straight from the RAM in AV_RD.
  assign readdata    = (state_q == AV_RD) ? ram_q : rdata_q;
  assign waitrequest = wait_c;
  assign MonDReg     = mon_d_q;
  assign jtag_busy   = jrd_q | jwr_q
                     | (state_q == J_RD)
                     | (state_q == J_WR);

endmodule
